// File: rtl/duplex_link_sched_if.sv
// Host-side and link-side signal bundle for the duplex link scheduler.
// The scheduler connects through the slave modport; hosts and the tx/rx FSM pair use the master modport.
interface duplex_link_sched_if #(
   parameter int DATA_WIDTH_BASE = 5
);
   localparam int W = 2 ** DATA_WIDTH_BASE;

   logic         req_a;
   logic [W-1:0] data_a;
   logic         gnt_a;
   logic         rsp_valid_a;
   logic         req_b;
   logic [W-1:0] data_b;
   logic         gnt_b;
   logic         rsp_valid_b;
   logic [W-1:0] rsp_data;
   logic         rsp_err;
   logic [1:0]   tx_cmd;
   logic [1:0]   rx_cmd;
   logic [W-1:0] tx_data;
   logic         tx_done;
   logic         rx_done;
   logic [W-1:0] rx_data;
   logic         busy;

   modport master (
      output req_a, data_a, req_b, data_b, tx_done, rx_done, rx_data,
      input  gnt_a, rsp_valid_a, gnt_b, rsp_valid_b, rsp_data, rsp_err,
             tx_cmd, rx_cmd, tx_data, busy
   );

   modport slave (
      input  req_a, data_a, req_b, data_b, tx_done, rx_done, rx_data,
      output gnt_a, rsp_valid_a, gnt_b, rsp_valid_b, rsp_data, rsp_err,
             tx_cmd, rx_cmd, tx_data, busy
   );
endinterface

// File: rtl/duplex_link_sched.sv
// Round-robin scheduler sharing one full-duplex tx/rx FSM pair between requesters A and B.
// Each transaction sends one word and receives one word; responses carry a timeout flag.
module duplex_link_sched #(
   parameter int DATA_WIDTH_BASE = 5,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input logic               clk,
   input logic               rst,
   duplex_link_sched_if.slave bus
);
   localparam int W  = 2 ** DATA_WIDTH_BASE;
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_START = 2'd1;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      RESP
   } state_t;

   state_t        state;
   logic          rr_ptr;
   logic          winner;
   logic [TW-1:0] timer;
   logic          tx_seen;
   logic          rx_seen;
   logic [W-1:0]  rx_word;

   logic          grant_b;
   logic          complete;

   // rr_ptr / winner encoding: 0 = A, 1 = B
   assign grant_b  = bus.req_b && (!bus.req_a || rr_ptr);
   assign complete = (tx_seen || bus.tx_done) && (rx_seen || bus.rx_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         rr_ptr          <= 1'b0;
         winner          <= 1'b0;
         timer           <= '0;
         tx_seen         <= 1'b0;
         rx_seen         <= 1'b0;
         rx_word         <= '0;
         bus.gnt_a       <= 1'b0;
         bus.gnt_b       <= 1'b0;
         bus.rsp_valid_a <= 1'b0;
         bus.rsp_valid_b <= 1'b0;
         bus.rsp_data    <= '0;
         bus.rsp_err     <= 1'b0;
         bus.tx_cmd      <= CMD_IDLE;
         bus.rx_cmd      <= CMD_IDLE;
         bus.tx_data     <= '0;
         bus.busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_a || bus.req_b) begin
                  winner      <= grant_b;
                  bus.gnt_a   <= !grant_b;
                  bus.gnt_b   <= grant_b;
                  bus.tx_data <= grant_b ? bus.data_b : bus.data_a;
                  bus.tx_cmd  <= CMD_START;
                  bus.rx_cmd  <= CMD_START;
                  bus.busy    <= 1'b1;
                  state       <= LAUNCH;
               end
            end

            LAUNCH: begin
               bus.gnt_a  <= 1'b0;
               bus.gnt_b  <= 1'b0;
               bus.tx_cmd <= CMD_IDLE;
               bus.rx_cmd <= CMD_IDLE;
               timer      <= '0;
               tx_seen    <= 1'b0;
               rx_seen    <= 1'b0;
               state      <= WAIT;
            end

            WAIT: begin
               if (bus.tx_done) begin
                  tx_seen <= 1'b1;
               end
               if (bus.rx_done) begin
                  rx_seen <= 1'b1;
                  rx_word <= bus.rx_data;
               end
               // Completion is checked before the timer so it wins a same-edge tie.
               if (complete) begin
                  bus.rsp_valid_a <= !winner;
                  bus.rsp_valid_b <= winner;
                  bus.rsp_err     <= 1'b0;
                  bus.rsp_data    <= bus.rx_done ? bus.rx_data : rx_word;
                  state           <= RESP;
               end else if (timer == TIMER_LAST) begin
                  bus.rsp_valid_a <= !winner;
                  bus.rsp_valid_b <= winner;
                  bus.rsp_err     <= 1'b1;
                  bus.rsp_data    <= '0;
                  state           <= RESP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            RESP: begin
               bus.rsp_valid_a <= 1'b0;
               bus.rsp_valid_b <= 1'b0;
               bus.rsp_err     <= 1'b0;
               bus.rsp_data    <= '0;
               bus.busy        <= 1'b0;
               rr_ptr          <= !winner;
               state           <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_duplex_link_sched.sv
// Directed bench for duplex_link_sched: stimulus pushes expected responses into a queue,
// and a negedge monitor pops and compares whenever a response pulse appears.
module tb_duplex_link_sched;
   logic clk;
   logic rst;

   duplex_link_sched_if #(.DATA_WIDTH_BASE(5)) bus ();

   duplex_link_sched #(
      .DATA_WIDTH_BASE(5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int          who;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic ra, input logic [31:0] da,
                                input logic rb, input logic [31:0] db);
      bus.req_a  = ra;
      bus.data_a = da;
      bus.req_b  = rb;
      bus.data_b = db;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      checkOutput({tag, "_ctrl"}, 64'({bus.gnt_a, bus.gnt_b, bus.rsp_valid_a, bus.rsp_valid_b,
                                       bus.rsp_err, bus.tx_cmd, bus.rx_cmd, bus.busy}), 64'd0);
      checkOutput({tag, "_data"}, {bus.tx_data, bus.rsp_data}, 64'd0);
   endtask

   // Waits for a grant; who: 0 = A, 1 = B, 3 = none within budget.
   task automatic grant(input int exp_who, input logic [31:0] exp_data, input int exp_lat);
      int who;
      int lat;
      who = 3;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.gnt_a || bus.gnt_b) begin
            who = bus.gnt_b ? 1 : 0;
            lat = i;
            break;
         end
      end
      checkOutput("grant_who", 64'(who), 64'(exp_who));
      if (who != 3) begin
         checkOutput("grant_tx_data", 64'(bus.tx_data), 64'(exp_data));
         checkOutput("grant_start_cmds", 64'({bus.tx_cmd, bus.rx_cmd, bus.busy}), 64'b01_01_1);
         if (exp_lat > 0) checkOutput("grant_latency", 64'(lat), 64'(exp_lat));
      end
   endtask

   // Called in LAUNCH; k-th WAIT edge samples the pulses when k equals tx_at / rx_at.
   task automatic serve(input int who, input int tx_at, input int rx_at, input int n,
                        input logic [31:0] word, input logic exp_err, input logic [31:0] exp_data);
      exp_t e;
      e.who  = who;
      e.data = exp_data;
      e.err  = exp_err;
      exp_q.push_back(e);
      step();
      checkOutput("launch_one_cycle", 64'({bus.gnt_a, bus.gnt_b, bus.tx_cmd, bus.rx_cmd}), 64'd0);
      checkOutput("busy_in_wait", 64'(bus.busy), 64'd1);
      for (int k = 1; k <= n; k++) begin
         if (k == n) checkOutput("rsp_early", 64'(bus.rsp_valid_a | bus.rsp_valid_b), 64'd0);
         bus.tx_done = (k == tx_at);
         bus.rx_done = (k == rx_at);
         bus.rx_data = (k == rx_at) ? word : ~word;
         step();
      end
      bus.tx_done = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = 32'h0;
      checkOutput("rsp_timing", 64'(bus.rsp_valid_a | bus.rsp_valid_b), 64'd1);
      step();
      checkOutput("resp_clear", 64'({bus.rsp_valid_a, bus.rsp_valid_b, bus.rsp_err, bus.rsp_data}), 64'd0);
      checkOutput("busy_idle", 64'(bus.busy), 64'd0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.gnt_a && bus.gnt_b) begin
         errors++;
         $display("[TB] FAIL gnt_exclusive: both grants high (t=%0t)", $time);
      end
      if (!rst && (bus.rsp_valid_a || bus.rsp_valid_b)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: va=%0b vb=%0b data=%0h, expected no response (t=%0t)",
                     bus.rsp_valid_a, bus.rsp_valid_b, bus.rsp_data, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("rsp_route", 64'({bus.rsp_valid_b, bus.rsp_valid_a}),
                        (e.who == 1) ? 64'b10 : 64'b01);
            checkOutput("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            checkOutput("rsp_err", 64'(bus.rsp_err), 64'(e.err));
         end
      end
   end

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      bus.tx_done = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = 32'h0;

      step();
      step();
      check_reset_state("reset");

      // Single request
      rst = 1'b0;
      applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 32'h0);
      grant(0, 32'hA5A5_0001, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      serve(0, 10, 12, 12, 32'h1234_5678, 1'b0, 32'h1234_5678);

      // Contention from reset: A, B, A
      rst = 1'b1;
      applyStimulus(1'b1, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002);
      step();
      check_reset_state("reset2");
      rst = 1'b0;
      grant(0, 32'hAAAA_0001, 1);
      serve(0, 2, 3, 3, 32'h0A0A_0A0A, 1'b0, 32'h0A0A_0A0A);
      grant(1, 32'hBBBB_0002, 1);
      serve(1, 3, 1, 3, 32'h0B0B_0B0B, 1'b0, 32'h0B0B_0B0B);
      grant(0, 32'hAAAA_0001, 1);
      serve(0, 1, 2, 2, 32'h0C0C_0C0C, 1'b0, 32'h0C0C_0C0C);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

      // Done ordering: rx before tx, then simultaneous
      applyStimulus(1'b1, 32'h0000_00D1, 1'b0, 32'h0);
      grant(0, 32'h0000_00D1, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      serve(0, 5, 2, 5, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA);
      applyStimulus(1'b1, 32'h0000_00D2, 1'b0, 32'h0);
      grant(0, 32'h0000_00D2, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      serve(0, 4, 4, 4, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);

      // Timeout with only tx_done, then a late rx_done that must be ignored
      applyStimulus(1'b1, 32'h0000_0070, 1'b0, 32'h0);
      grant(0, 32'h0000_0070, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      serve(0, 3, 0, 16, 32'h7777_7777, 1'b1, 32'h0);
      step();
      bus.rx_done = 1'b1;
      bus.rx_data = 32'h7777_7777;
      step();
      bus.rx_done = 1'b0;
      bus.rx_data = 32'h0;
      checkOutput("late_done_busy", 64'(bus.busy), 64'd0);
      checkOutput("late_done_no_rsp", 64'(bus.rsp_valid_a | bus.rsp_valid_b), 64'd0);
      step();
      checkOutput("late_done_no_rsp2", 64'(bus.rsp_valid_a | bus.rsp_valid_b), 64'd0);

      // Reset mid-WAIT with B pending
      applyStimulus(1'b1, 32'h1111_2222, 1'b0, 32'h0);
      grant(0, 32'h1111_2222, 1);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h3333_4444);
      step();
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check_reset_state("reset_mid_wait");
      rst = 1'b0;
      grant(1, 32'h3333_4444, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      serve(1, 2, 2, 2, 32'h4444_5555, 1'b0, 32'h4444_5555);

      // Completion on the last WAIT cycle beats the timeout
      applyStimulus(1'b1, 32'h0000_0016, 1'b0, 32'h0);
      grant(0, 32'h0000_0016, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      serve(0, 16, 16, 16, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
      applyStimulus(1'b1, 32'h0000_0017, 1'b0, 32'h0);
      grant(0, 32'h0000_0017, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      serve(0, 16, 7, 16, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE);

      repeat (3) step();
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/duplex_link_sched.md
Name: duplex_link_sched

Overview:
- Shares one full-duplex serial link (one transmit FSM plus one receive FSM) between two requesters, A and B.
- Each accepted request is one transaction: send one word and receive one word at the same time.
- Round-robin arbitration; launches both FSMs with a one-cycle start code, waits for both completion pulses, captures the received word and returns it with a timeout error flag.
- Sits between host logic and the tx/rx FSM pair.

Parameters:
- DATA_WIDTH_BASE, 5, word width W = 2**DATA_WIDTH_BASE (default 32).
- TIMEOUT_CYCLES, 256, maximum WAIT cycles before a transaction is failed; must be >= 2.

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_a  in  1  requester A request; held until gnt_a
- data_a  in  W  requester A transmit word
- gnt_a  out  1  one-cycle acceptance pulse to A
- rsp_valid_a  out  1  one-cycle response pulse to A
- req_b  in  1  requester B request
- data_b  in  W  requester B transmit word
- gnt_b  out  1  one-cycle acceptance pulse to B
- rsp_valid_b  out  1  one-cycle response pulse to B
- rsp_data  out  W  received word; valid while rsp_valid_a or rsp_valid_b is high
- rsp_err  out  1  timeout flag; valid while a rsp_valid is high
- tx_cmd  out  2  state code to transmit FSM (1 = start, 0 = idle)
- rx_cmd  out  2  state code to receive FSM (1 = start, 0 = idle)
- tx_data  out  W  word presented to the transmit FSM
- tx_done  in  1  transmit FSM end pulse
- rx_done  in  1  receive FSM end pulse
- rx_data  in  W  receive FSM word; valid in the cycle rx_done is high
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output is 0; state = IDLE; rr_ptr = A; timer = 0; done flags cleared. Reset mid-transaction aborts to IDLE immediately with no response pulse.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req_a or req_b is high at a clock edge, the winner is chosen as follows: only one requesting gets the grant; both requesting resolves to rr_ptr.
  - At that edge: state <= LAUNCH; gnt_x <= 1; tx_data <= data_x; tx_cmd <= 1; rx_cmd <= 1; winner id is latched.
  - Grant and start therefore appear 1 cycle after req is sampled.
- LAUNCH (exactly 1 cycle): next edge sets gnt_x <= 0, tx_cmd <= 0, rx_cmd <= 0, timer <= 0, tx_seen <= 0, rx_seen <= 0, state <= WAIT. Start codes are never high for more than 1 cycle.
- WAIT:
  - Each edge: tx_done sets tx_seen. rx_done sets rx_seen and captures rx_data into rx_word.
  - Completion = (tx_seen or tx_done) and (rx_seen or rx_done). Pulses arriving in the same cycle, or in either order, are both accepted.
  - On completion: state <= RESP, rsp_valid_winner <= 1, rsp_err <= 0, rsp_data <= rx_word, or rx_data if rx_done arrives this cycle.
  - Otherwise timer += 1. If timer == TIMEOUT_CYCLES-1 and there is no completion: state <= RESP, rsp_err <= 1, rsp_data <= 0.
  - Completion wins over timeout when both happen on the same edge.
- RESP (exactly 1 cycle): next edge clears rsp_valid_x, rsp_err and rsp_data to 0. rr_ptr <= the requester that did not just complete. state <= IDLE.
- Done pulses sampled outside WAIT (including late pulses after a timeout) are ignored.
- Requests:
  - A req dropped before its gnt is simply not served.
  - A req still high in IDLE after its RESP is a new request.
  - Minimum request-to-request spacing for one requester is 3 cycles plus the WAIT duration.
- rsp_valid_a and rsp_valid_b are never high together. gnt_a and gnt_b are never high together.
- Timer width is clog2(TIMEOUT_CYCLES). It never wraps, because it is cleared in LAUNCH.

Test Plan:
- Single request: req_a=1, data_a=32'hA5A5_0001; bench pulses tx_done at WAIT+10 and rx_done with rx_data=32'h1234_5678 at WAIT+12.
  -> gnt_a and tx_cmd=rx_cmd=1 for exactly 1 cycle, 1 cycle after req; tx_data=32'hA5A5_0001; rsp_valid_a for 1 cycle with rsp_data=32'h1234_5678, rsp_err=0.
- Contention: req_a and req_b both high from reset.
  -> A granted first, then B, then A; grants alternate while both stay high; rsp_valid is routed to the matching requester.
- Done ordering: rx_done before tx_done, then a run with tx_done and rx_done in the same cycle (rx_data=32'hDEAD_BEEF).
  -> In both runs the response arrives the edge after the final pulse; the simultaneous run returns rsp_data=32'hDEAD_BEEF.
- Timeout: TIMEOUT_CYCLES=16, only tx_done is given.
  -> rsp_valid with rsp_err=1 and rsp_data=0 exactly 16 cycles after entering WAIT. A rx_done pulse 3 cycles later is ignored (state IDLE, no response).
- Reset mid-WAIT: assert rst for 1 cycle during WAIT.
  -> Next cycle all outputs are 0, busy=0, no rsp_valid; after release a pending req_b is granted (rr_ptr=A, but B is the only requester).
- Completion and timeout together: TIMEOUT_CYCLES=16, last done pulse on the 16th WAIT cycle.
  -> rsp_err=0 and the captured data is returned.
